// File: rtl/magic_nor_sequencer.sv
// magic_nor_sequencer: fetches inv1/nor2 gate words and issues MAGIC INIT/EVAL/READ commands to a crossbar
module magic_nor_sequencer #(
  parameter int ADDR_W = 6,
  parameter int PC_W = 8,
  parameter int NUM_OUT = 4,
  localparam int INSTR_W = 2 + 3*ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NUM_OUT-1:0] result,
  output logic [15:0]        op_count,
  output logic               pmem_en,
  output logic [PC_W-1:0]    pmem_addr,
  input  logic [INSTR_W-1:0] pmem_rdata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [ADDR_W-1:0]  cmd_a,
  output logic [ADDR_W-1:0]  cmd_b,
  output logic [ADDR_W-1:0]  cmd_c,
  input  logic               rd_valid,
  input  logic               rd_data
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_INIT = 3'd3,
                         S_EVAL = 3'd4, S_RD = 3'd5, S_RD_WAIT = 3'd6, S_DONE = 3'd7;
  localparam int RW = $clog2(NUM_OUT + 1);
  logic [2:0] state;
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] instr;
  logic [RW-1:0] rd_idx;
  logic abort_q;
  logic [1:0] op, nop;
  logic [ADDR_W-1:0] a, b, c;
  logic accept, kill, adv;
  assign op = instr[INSTR_W-1 -: 2];
  assign nop = pmem_rdata[INSTR_W-1 -: 2];
  assign a = instr[3*ADDR_W-1 -: ADDR_W];
  assign b = instr[2*ADDR_W-1 -: ADDR_W];
  assign c = instr[ADDR_W-1:0];
  assign busy = state != S_IDLE;
  assign done = state == S_DONE && !abort;
  assign pmem_en = state == S_FETCH;
  assign pmem_addr = pc;
  assign cmd_valid = state == S_INIT || state == S_EVAL || state == S_RD;
  assign cmd_op = state == S_RD ? 2'b11 : state == S_EVAL ? (op == 2'b00 ? 2'b01 : 2'b10) : 2'b00;
  assign cmd_a = (state == S_EVAL || state == S_RD) ? a : '0;
  assign cmd_b = (state == S_EVAL && op == 2'b00) ? b : '0;
  assign cmd_c = (state == S_INIT || state == S_EVAL) ? c : '0;
  assign accept = cmd_valid && cmd_ready;
  // an abort seen while a command is pending is remembered until that handshake completes
  assign kill = abort || abort_q;
  assign adv = (state == S_EVAL && accept && !kill) || (state == S_RD_WAIT && !abort && rd_valid);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= '0;
      instr <= '0;
      rd_idx <= '0;
      abort_q <= 1'b0;
      result <= '0;
      op_count <= '0;
      err <= 1'b0;
    end else begin
      if (accept && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (cmd_valid && abort) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start && !abort) begin
            state <= S_FETCH;
            pc <= '0;
            result <= '0;
            op_count <= '0;
            err <= 1'b0;
            rd_idx <= '0;
          end
        end
        S_FETCH: state <= abort ? S_IDLE : S_DECODE;
        S_DECODE: begin
          instr <= pmem_rdata;
          state <= abort ? S_IDLE : nop == 2'b11 ? S_DONE : nop == 2'b10 ? S_RD : S_INIT;
        end
        S_INIT: if (accept) state <= kill ? S_IDLE : S_EVAL;
        S_EVAL: if (accept && kill) state <= S_IDLE;
        S_RD: if (accept) state <= kill ? S_IDLE : S_RD_WAIT;
        S_RD_WAIT: begin
          if (abort) state <= S_IDLE;
          else if (rd_valid && rd_idx < RW'(NUM_OUT)) begin
            for (int k = 0; k < NUM_OUT; k++) if (rd_idx == RW'(k)) result[k] <= rd_data;
            rd_idx <= rd_idx + RW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      // the last program slot never wraps: running past it is an error
      if (adv) begin
        if (&pc) begin
          err <= 1'b1;
          state <= S_DONE;
        end else begin
          pc <= pc + PC_W'(1);
          state <= S_FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_magic_nor_sequencer.sv
// tb_magic_nor_sequencer: directed programs checked against a gate-list walking model
module tb_magic_nor_sequencer;
  localparam int AW = 6, PW = 8, NO = 4, IW = 2 + 3*AW;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, cmd_ready = 1, rd_valid = 0, rd_data = 0;
  logic busy, done, err, pmem_en, cmd_valid;
  logic [NO-1:0] result;
  logic [15:0] op_count;
  logic [PW-1:0] pmem_addr;
  logic [IW-1:0] pmem_rdata = '0;
  logic [1:0] cmd_op;
  logic [AW-1:0] cmd_a, cmd_b, cmd_c;
  logic [IW-1:0] mem [256];
  int total = 0, bad = 0;
  logic [19:0] exp_q[$];
  logic [3:0] exp_res;
  int exp_ops;
  logic exp_err;
  int rbits[$], rd_q[$];
  int n_acc = 0, gate_cyc = 0, done_cnt = 0, cyc = 0, force_cnt = 0;
  bit chk_en = 0, rd_hold = 0;

  magic_nor_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .result(result), .op_count(op_count), .pmem_en(pmem_en), .pmem_addr(pmem_addr),
    .pmem_rdata(pmem_rdata), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (pmem_en) pmem_rdata <= mem[pmem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] ins(input logic [1:0] o, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {o, a, b, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = ins(2'd3, 6'd0, 6'd0, 6'd0);
  endtask

  // walk the gate list: each gate = INIT + EVAL, READ = one command, END stops
  task automatic build();
    int r;
    logic [1:0] o;
    logic [5:0] a, b, c;
    r = 0;
    exp_q = {};
    exp_res = '0;
    exp_err = 1'b0;
    for (int p = 0; p < 256; p++) begin
      {o, a, b, c} = mem[p];
      if (o == 2'd3) break;
      if (o == 2'd2) begin
        exp_q.push_back({2'b11, a, 6'd0, 6'd0});
        if (r < NO) exp_res[r] = rbits[r][0];
        r++;
      end else begin
        exp_q.push_back({2'b00, 6'd0, 6'd0, c});
        exp_q.push_back({o == 2'd0 ? 2'b01 : 2'b10, a, o == 2'd0 ? b : 6'd0, c});
      end
      if (p == 255) exp_err = 1'b1;
    end
    exp_ops = exp_q.size();
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!cmd_valid && n < 20) begin tick(); n++; end
    chk(nm, cmd_valid, 1);
  endtask

  task automatic run(input int budget, input string nm);
    int n = 0;
    start = 1;
    tick();
    start = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk({nm, "_done"}, done, 1);
    tick();
  endtask

  // crossbar read side: answers each accepted READ once, plus optional stray pulses
  initial begin
    int owed = 0;
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready && cmd_op == 2'b11) owed++;
      @(posedge clk);
      #2;
      rd_valid = 0;
      rd_data = 0;
      if (!rst_n) owed = 0;
      else if (force_cnt > 0) begin
        rd_valid = 1;
        rd_data = 1;
        force_cnt--;
      end else if (owed > 0 && !rd_hold && rd_q.size() > 0) begin
        rd_valid = 1;
        rd_data = rd_q.pop_front() != 0;
        owed--;
      end
    end
  end

  // compare process: command order/content, handshake stability, live op_count, completion
  initial begin
    logic pv = 0;
    logic [19:0] pf = '0, cur, want;
    forever begin
      @(negedge clk);
      if (!rst_n || (start && !busy && !abort)) begin
        n_acc = 0;
        cyc = 0;
        done_cnt = 0;
        pv = 0;
      end else if (busy) cyc++;
      cur = {cmd_op, cmd_a, cmd_b, cmd_c};
      if (chk_en && rst_n) begin
        if (busy) chk("op_count_live", op_count, n_acc);
        if (pv) chk("cmd_stable", {11'd0, cmd_valid, cur}, {11'd0, 1'b1, pf});
        if (cmd_valid && cmd_ready) begin
          want = n_acc < exp_q.size() ? exp_q[n_acc] : 20'hFFFFF;
          chk("cmd_seq", cur, want);
          if (n_acc == 1) gate_cyc = cyc;
          n_acc++;
        end
        if (done) begin
          done_cnt++;
          chk("done_result", result, exp_res);
          chk("done_op_count", op_count, exp_ops);
          chk("done_err", err, exp_err);
          chk("done_ncmd", n_acc, exp_ops);
        end
      end
      pv = rst_n && busy && cmd_valid && !cmd_ready;
      pf = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clear_mem();
    repeat (2) tick();
    chk("rst_outs", {busy, done, err, result, op_count, cmd_valid, pmem_en, pmem_addr}, 0);
    rst_n = 1;
    tick();
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("abort_wins_idle", busy, 0);
    chk_en = 1;
    // single NOR2 then READ
    mem[0] = ins(2'd0, 6'd0, 6'd1, 6'd8);
    mem[1] = ins(2'd2, 6'd8, 6'd0, 6'd0);
    rbits = {1};
    rd_q = rbits;
    build();
    chk("model_t1_len", exp_q.size(), 3);
    chk("model_t1_eval", exp_q[1], {2'b01, 6'd0, 6'd1, 6'd8});
    run(50, "t1");
    chk("t1_result", result, 4'b0001);
    chk("t1_op_count", op_count, 3);
    chk("t1_err", err, 0);
    chk("t1_gate_latency", gate_cyc, 4);
    // INIT stalled for 5 cycles
    clear_mem();
    mem[0] = ins(2'd1, 6'd3, 6'd0, 6'd9);
    rbits = {};
    build();
    cmd_ready = 0;
    start = 1;
    tick();
    start = 0;
    wait_valid("t2_wait");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold", {cmd_valid, cmd_op, cmd_c}, {1'b1, 2'b00, 6'd9});
      tick();
    end
    cmd_ready = 1;
    for (int i = 0; i < 10 && !done; i++) tick();
    chk("t2_done", done, 1);
    tick();
    chk("t2_op_count", op_count, 2);
    // full program of NOR2 with no END
    for (int i = 0; i < 256; i++) mem[i] = ins(2'd0, 6'(i % 8), 6'((i + 1) % 8), 6'(8 + i % 50));
    build();
    chk("model_t3_ops", exp_ops, 512);
    run(2000, "t3");
    chk("t3_err", err, 1);
    chk("t3_pc", pmem_addr, 255);
    chk("t3_op_count", op_count, 512);
    // abort while EVAL is stalled
    clear_mem();
    mem[0] = ins(2'd0, 6'd2, 6'd3, 6'd10);
    build();
    cmd_ready = 0;
    start = 1;
    tick();
    start = 0;
    wait_valid("t4_wait");
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    chk("t4_eval_op", {cmd_valid, cmd_op}, 3'b101);
    abort = 1;
    tick();
    abort = 0;
    tick();
    tick();
    chk("t4_still_busy", busy, 1);
    cmd_ready = 1;
    tick();
    chk("t4_idle", busy, 0);
    tick();
    tick();
    chk("t4_no_done", done_cnt, 0);
    chk("t4_op_count", op_count, 2);
    chk("t4_ncmd", n_acc, 2);
    // six READs into a four-bit result
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = ins(2'd2, 6'(8 + i), 6'd0, 6'd0);
    rbits = {1, 0, 1, 1, 0, 0};
    rd_q = rbits;
    build();
    chk("model_t5_res", exp_res, 4'b1101);
    run(100, "t5");
    chk("t5_result", result, 4'b1101);
    chk("t5_op_count", op_count, 6);
    // INV1, NOR2 and two READs
    clear_mem();
    mem[0] = ins(2'd1, 6'd3, 6'd0, 6'd9);
    mem[1] = ins(2'd0, 6'd5, 6'd7, 6'd10);
    mem[2] = ins(2'd2, 6'd9, 6'd0, 6'd0);
    mem[3] = ins(2'd2, 6'd10, 6'd0, 6'd0);
    rbits = {0, 1};
    rd_q = rbits;
    build();
    run(100, "t6");
    chk("t6_result", result, 4'b0010);
    chk("t6_op_count", op_count, 6);
    // reset while waiting on read data, then a clean rerun
    clear_mem();
    mem[0] = ins(2'd2, 6'd8, 6'd0, 6'd0);
    rbits = {1};
    rd_q = rbits;
    rd_hold = 1;
    build();
    start = 1;
    tick();
    start = 0;
    wait_valid("t7_wait");
    tick();
    tick();
    chk("t7_in_rdwait", busy, 1);
    rst_n = 0;
    tick();
    chk("t7_rst_outs", {busy, done, err, result, op_count, cmd_valid, pmem_en, pmem_addr}, 0);
    rst_n = 1;
    rd_hold = 0;
    rbits = {0};
    rd_q = rbits;
    build();
    tick();
    force_cnt = 4;
    run(50, "t7");
    chk("t7_result", result, 4'b0000);
    chk("t7_op_count", op_count, 1);
    chk("t7_pc", pmem_addr, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
